// File: rtl/traceback.sv
// Viterbi traceback unit.
// Walks the survivor memory backwards from the newest column and the best end
// state, one column per READ/STEP pair, and collects the oldest OUT_LEN decoded
// bits. The survivor memory has a registered read port, so each READ cycle
// presents an address and the following STEP cycle consumes the returned word.
module traceback #(
    parameter int DEPTH   = 32,
    parameter int OUT_LEN = 16
) (
    input  logic               clk,
    input  logic               RSTn,
    input  logic               start,
    input  logic [4:0]         start_addr,
    input  logic [5:0]         start_state,
    output logic [4:0]         mem_addr,
    input  logic [63:0]        mem_d,
    output logic               busy,
    output logic [OUT_LEN-1:0] dec_o,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        STEP
    } fsm_t;

    // Step index of the final column, and the first step whose bit is kept.
    localparam logic [4:0] LAST_K    = 5'(DEPTH - 1);
    localparam logic [4:0] FIRST_OUT = 5'(DEPTH - OUT_LEN);

    fsm_t               fsm_q, fsm_d;
    logic [5:0]         st_q, st_d;
    logic [4:0]         k_q, k_d;
    logic [4:0]         addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [OUT_LEN-1:0] dec_q, dec_d;
    logic               decision;
    logic [4:0]         out_idx;

    // Next-state logic: the address register is loaded on the way into READ so
    // it is stable for the whole READ cycle and then simply held. A start that
    // arrives while done is still pulsing is dropped so a new run can only
    // begin the cycle after done.
    always_comb begin
        fsm_d    = fsm_q;
        st_d     = st_q;
        k_d      = k_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dec_d    = dec_q;
        decision = mem_d[st_q];
        out_idx  = LAST_K - k_q;

        case (fsm_q)
            IDLE: begin
                if (start && !done_q) begin
                    addr_d = start_addr;
                    st_d   = start_state;
                    k_d    = 5'd0;
                    busy_d = 1'b1;
                    fsm_d  = READ;
                end
            end

            READ: begin
                fsm_d = STEP;
            end

            STEP: begin
                st_d = {st_q[4:0], decision};
                if (k_q >= FIRST_OUT) begin
                    for (int i = 0; i < OUT_LEN; i++) begin
                        if (32'(out_idx) == i) begin
                            dec_d[i] = st_q[5];
                        end
                    end
                end
                if (k_q == LAST_K) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = IDLE;
                end else begin
                    k_d    = k_q + 5'd1;
                    addr_d = addr_q - 5'd1;
                    fsm_d  = READ;
                end
            end

            default: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any run in progress and clears the result.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            fsm_q  <= IDLE;
            st_q   <= 6'd0;
            k_q    <= 5'd0;
            addr_q <= 5'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dec_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            k_q    <= k_d;
            addr_q <= addr_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dec_q  <= dec_d;
        end
    end

    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dec_o    = dec_q;

endmodule

// File: tb/tb_traceback.sv
// Scoreboard bench for the traceback unit: one default-sized instance and one
// DEPTH=4 instance, each with its own registered-read survivor memory model.
module tb_traceback;

    typedef struct {
        logic [15:0] dec;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    // Default instance (DEPTH=32, OUT_LEN=16)
    logic        start = 1'b0;
    logic [4:0]  start_addr = 5'd0;
    logic [5:0]  start_state = 6'd0;
    logic [4:0]  mem_addr;
    logic [63:0] mem_d = 64'd0;
    logic        busy;
    logic [15:0] dec_o;
    logic        done;
    logic [63:0] mem [32];
    exp_t        sb_q[$];
    exp_t        e;

    // Small instance (DEPTH=4, OUT_LEN=4)
    logic        start4 = 1'b0;
    logic [4:0]  start_addr4 = 5'd0;
    logic [5:0]  start_state4 = 6'd0;
    logic [4:0]  mem_addr4;
    logic [63:0] mem_d4 = 64'd0;
    logic        busy4;
    logic [3:0]  dec4;
    logic        done4;
    logic [63:0] mem4 [32];
    exp_t        sb4_q[$];
    exp_t        e4;

    traceback dut (
        .clk(clk), .RSTn(RSTn), .start(start), .start_addr(start_addr),
        .start_state(start_state), .mem_addr(mem_addr), .mem_d(mem_d),
        .busy(busy), .dec_o(dec_o), .done(done)
    );

    traceback #(.DEPTH(4), .OUT_LEN(4)) dut4 (
        .clk(clk), .RSTn(RSTn), .start(start4), .start_addr(start_addr4),
        .start_state(start_state4), .mem_addr(mem_addr4), .mem_d(mem_d4),
        .busy(busy4), .dec_o(dec4), .done(done4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Survivor memories with one-cycle registered read.
    always @(posedge clk) begin
        mem_d  <= mem[mem_addr];
        mem_d4 <= mem4[mem_addr4];
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor for the default instance: every done must match the oldest expectation.
    always @(negedge clk) begin
        if (RSTn && done) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
            end else begin
                e = sb_q.pop_front();
                check_output("done_cycle", 64'(cyc), 64'(e.cyc));
                check_output("dec_o", 64'(dec_o), 64'(e.dec));
            end
        end
    end

    // Monitor for the DEPTH=4 instance.
    always @(negedge clk) begin
        if (RSTn && done4) begin
            if (sb4_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done4: got done=1 at cycle %0d want no done", cyc);
            end else begin
                e4 = sb4_q.pop_front();
                check_output("done4_cycle", 64'(cyc), 64'(e4.cyc));
                check_output("dec4", 64'(dec4), 64'(e4.dec));
            end
        end
    end

    task automatic apply_stimulus(input logic [4:0] a, input logic [5:0] s, input logic [15:0] want);
        exp_t x;
        @(posedge clk);
        #1;
        start_addr  = a;
        start_state = s;
        start       = 1'b1;
        x.dec = want;
        x.cyc = cyc + 65;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || sb4_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_output("drain_pending", 64'(sb_q.size() + sb4_q.size()), 64'd0);
        sb_q.delete();
        sb4_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] seq;
        logic [5:0]  s;
        logic [5:0]  ns;
        logic [63:0] w;
        int          addr_err;
        exp_t        x;

        foreach (mem[i]) mem[i] = 64'd0;
        foreach (mem4[i]) mem4[i] = 64'd0;

        // Reset values
        repeat (2) @(negedge clk);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_dec", 64'(dec_o), 64'd0);
        check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_output("rst_dec4", 64'(dec4), 64'd0);
        @(posedge clk);
        #1;
        RSTn = 1'b1;

        // All-zero memory, address walk 5,4,...,0,31,...,6
        apply_stimulus(5'd5, 6'd0, 16'h0000);
        check_output("busy_in_run", 64'(busy), 64'd1);
        addr_err = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (mem_addr !== 5'(5 - k)) addr_err++;
            @(negedge clk);
        end
        check_output("addr_seq_errors", 64'(addr_err), 64'd0);
        wait_drain(100);

        // All-ones memory from state 3F, then a start during done (dropped)
        // followed by a start the next cycle (accepted).
        foreach (mem[i]) mem[i] = {64{1'b1}};
        apply_stimulus(5'd0, 6'h3F, 16'hFFFF);
        repeat (64) @(posedge clk);
        #1;
        start_addr  = 5'd9;
        start_state = 6'h3F;
        start       = 1'b1;
        x.dec = 16'hFFFF;
        x.cyc = cyc + 66;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("start_on_done_ignored", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_output("start_after_done_busy", 64'(busy), 64'd1);
        wait_drain(200);

        // Encoded sequence, columns 7..31,0..6, state={u,s[5:1]} from 0.
        seq = 32'hA5C3_96E1;
        s = 6'd0;
        for (int t = 0; t < 32; t++) begin
            ns = {seq[t], s[5:1]};
            w = {$urandom, $urandom};
            w[ns] = s[0];
            mem[(7 + t) % 32] = w;
            s = ns;
        end
        apply_stimulus(5'd6, s, 16'h96E1);
        wait_drain(100);

        // Same memory, second start at cycle 10 of the run is ignored.
        apply_stimulus(5'd6, s, 16'h96E1);
        repeat (9) @(posedge clk);
        #1;
        start_addr  = 5'd20;
        start_state = 6'h15;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain(100);

        // Reset at cycle 20 of a run: run aborted, result cleared, no done.
        apply_stimulus(5'd6, s, 16'h96E1);
        repeat (19) @(posedge clk);
        #1;
        RSTn = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_done", 64'(done), 64'd0);
        check_output("abort_dec", 64'(dec_o), 64'd0);
        check_output("abort_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge clk);
        #1;
        RSTn = 1'b1;
        repeat (70) @(posedge clk);
        foreach (mem[i]) mem[i] = {64{1'b1}};
        apply_stimulus(5'd12, 6'h3F, 16'hFFFF);
        wait_drain(100);

        // DEPTH=4 instance: zero memory from state 2C gives 1011, done at +9.
        @(posedge clk);
        #1;
        start_addr4  = 5'd2;
        start_state4 = 6'h2C;
        start4       = 1'b1;
        x.dec = 16'h000B;
        x.cyc = cyc + 9;
        sb4_q.push_back(x);
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(negedge clk);
        check_output("busy4_in_run", 64'(busy4), 64'd1);
        check_output("mem_addr4_first", 64'(mem_addr4), 64'd2);
        wait_drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
